// File: rtl/fpu_pkg.sv
// Shared widths, IEEE-754 constants and types for the FPU operand path.
// The unpacked_t layout matches what the rounder/packer consumes.
package fpu_pkg;

   localparam int EXP_W = 13;
   localparam int SIG_W = 53;

   localparam logic [EXP_W-1:0] BIAS_D  = 13'd1023;
   localparam logic [EXP_W-1:0] BIAS_S  = 13'd127;
   localparam logic [10:0]      EMAXF_D = 11'd2047;
   localparam logic [10:0]      EMAXF_S = 11'd255;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      DONE
   } state_t;

   typedef struct packed {
      logic zero;
      logic inf;
      logic nan;
      logic snan;
      logic denorm;
   } flags_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] er;
      logic [SIG_W-1:0] fr;
      logic [5:0]       lz;
      flags_t           flags;
   } unpacked_t;

endpackage

// File: rtl/lzc_step.sv
// Leading-zero count of a significand, saturated at SHIFT_STEP so the
// normaliser never shifts further than one step allows in a single cycle.
module lzc_step
   import fpu_pkg::*;
#(
   parameter int SHIFT_STEP = 8
) (
   input  logic [SIG_W-1:0] fr_i,
   output logic [6:0]       cnt_o
);

   logic [6:0] full_cnt;

   always_comb begin
      full_cnt = 7'(SIG_W);
      // Scanning upward lets the most significant set bit win.
      for (int i = 0; i < SIG_W; i++) begin
         if (fr_i[i]) begin
            full_cnt = 7'(SIG_W - 1 - i);
         end
      end
      cnt_o = (full_cnt > 7'(SHIFT_STEP)) ? 7'(SHIFT_STEP) : full_cnt;
   end

endmodule

// File: rtl/fp_unpack_seq.sv
// Sequential IEEE-754 single/double unpacker: classifies the operand and
// normalises denormals up to SHIFT_STEP bit positions per cycle.
module fp_unpack_seq
   import fpu_pkg::*;
#(
   parameter int SHIFT_STEP = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      operand,
   input  logic             db,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sign,
   output logic [EXP_W-1:0] er,
   output logic [SIG_W-1:0] fr,
   output logic [5:0]       lz,
   output logic             ZERO,
   output logic             INF,
   output logic             NAN,
   output logic             SNAN,
   output logic             DENORM
);

   state_t           state_q, state_d;
   unpacked_t        res_q, res_d;

   logic             sign_f;
   logic [10:0]      exp_f;
   logic [51:0]      frac_f;
   logic [EXP_W-1:0] bias;
   logic [10:0]      emaxf;
   logic [6:0]       step_k;
   logic [SIG_W-1:0] fr_shift;

   // Singles are left-aligned into the double fraction field.
   assign sign_f = db ? operand[63]     : operand[31];
   assign exp_f  = db ? operand[62:52]  : {3'b000, operand[30:23]};
   assign frac_f = db ? operand[51:0]   : {operand[22:0], 29'd0};
   assign bias   = db ? BIAS_D  : BIAS_S;
   assign emaxf  = db ? EMAXF_D : EMAXF_S;

   lzc_step #(
      .SHIFT_STEP (SHIFT_STEP)
   ) u_lzc_step (
      .fr_i  (res_q.fr),
      .cnt_o (step_k)
   );

   assign fr_shift = res_q.fr << step_k;

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               res_d      = '0;
               res_d.sign = sign_f;
               if (exp_f == 11'd0 && frac_f == 52'd0) begin
                  res_d.flags.zero = 1'b1;
                  state_d          = DONE;
               end else if (exp_f == 11'd0) begin
                  res_d.flags.denorm = 1'b1;
                  res_d.fr           = {1'b0, frac_f};
                  res_d.er           = 13'd1 - bias;
                  state_d            = NORM;
               end else begin
                  res_d.er = {2'b00, exp_f} - bias;
                  res_d.fr = {1'b1, frac_f};
                  if (exp_f == emaxf) begin
                     res_d.flags.inf  = (frac_f == 52'd0);
                     res_d.flags.nan  = (frac_f != 52'd0);
                     res_d.flags.snan = (frac_f != 52'd0) && !frac_f[51];
                  end
                  state_d = DONE;
               end
            end
         end
         NORM: begin
            res_d.fr = fr_shift;
            res_d.er = res_q.er - {6'd0, step_k};
            res_d.lz = res_q.lz + step_k[5:0];
            if (fr_shift[SIG_W-1]) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sign      = res_q.sign;
   assign er        = res_q.er;
   assign fr        = res_q.fr;
   assign lz        = res_q.lz;
   assign ZERO      = res_q.flags.zero;
   assign INF       = res_q.flags.inf;
   assign NAN       = res_q.flags.nan;
   assign SNAN      = res_q.flags.snan;
   assign DENORM    = res_q.flags.denorm;

endmodule
